// File: rtl/vlc_bit_packer_pkg.sv
// Shared constants and FSM encoding for the VLC bit packer.
//   MAX_LEN : maximum codeword length, also the output word width
//   ACC_W   : accumulator width (two output words)
//   LEN_W   : width of the codeword length field
//   FILL_W  : width of the accumulator fill counter (0..ACC_W)
//   BYTES_W : width of the valid-byte count on the output word
package vlc_bit_packer_pkg;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned ACC_W   = 2 * MAX_LEN;
  localparam int unsigned LEN_W   = 6;
  localparam int unsigned FILL_W  = 7;
  localparam int unsigned BYTES_W = 3;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LAST  = 2'd2
  } state_e;

endpackage

// File: rtl/vlc_code_align.sv
// Masks a right-aligned codeword to its length and shifts it to the insertion
// point just below the currently valid bits of the MSB-aligned accumulator.
//   code : right-aligned codeword, bits at and above len are discarded
//   len  : effective codeword length 0..MAX_LEN
//   fill : accumulator fill after any pop in the same cycle
//   ins  : codeword positioned for OR-ing into the accumulator
module vlc_code_align
  import vlc_bit_packer_pkg::*;
(
  input  logic [MAX_LEN-1:0] code,
  input  logic [LEN_W-1:0]   len,
  input  logic [FILL_W-1:0]  fill,
  output logic [ACC_W-1:0]   ins
);

  logic [ACC_W-1:0]  mask;
  logic [ACC_W-1:0]  masked;
  logic [FILL_W-1:0] shamt;

  // Caller guarantees fill+len <= ACC_W; a shift of ACC_W only occurs with len=0.
  always_comb begin
    mask   = (ACC_W'(1) << len) - ACC_W'(1);
    masked = {{(ACC_W - MAX_LEN){1'b0}}, code} & mask;
    shamt  = FILL_W'(ACC_W) - fill - FILL_W'(len);
    ins    = masked << shamt;
  end

endmodule

// File: rtl/vlc_bit_packer.sv
// Concatenates variable-length codewords MSB-first into 32-bit stream words.
// A flush drains complete words, then emits a zero-padded last word with its
// valid byte count and pulses flush_done.
//   clk, reset             : clock, synchronous active-high reset
//   in_valid/in_ready      : codeword handshake (in_code, in_len)
//   flush                  : one-cycle drain request, honoured only in RUN
//   out_valid/out_ready    : word handshake (out_data, out_last, out_bytes)
//   flush_done             : one-cycle pulse once a flush has fully drained
//   len_err                : sticky, a codeword with in_len > MAX_LEN was taken
//   bit_count              : codeword bits accepted since reset, wrapping
module vlc_bit_packer
  import vlc_bit_packer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_LEN-1:0]  in_code,
  input  logic [LEN_W-1:0]    in_len,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MAX_LEN-1:0]  out_data,
  output logic                out_last,
  output logic [BYTES_W-1:0]  out_bytes,
  output logic                flush_done,
  output logic                len_err,
  output logic [CNT_W-1:0]    bit_count
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_s;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_s;
  logic               flush_done_q, flush_done_d;
  logic               len_err_q, len_err_d;
  logic [CNT_W-1:0]   bit_count_q, bit_count_d;

  logic               pop;
  logic               accept;
  logic               len_big;
  logic [LEN_W-1:0]   len_eff;
  logic [ACC_W-1:0]   ins;

  // Outputs depend only on registered state (in_ready is also held low in reset).
  always_comb begin
    out_valid  = (fill_q >= FILL_W'(MAX_LEN)) | (state_q == ST_LAST);
    out_data   = acc_q[ACC_W-1 -: MAX_LEN];
    out_last   = (state_q == ST_LAST);
    out_bytes  = out_last ? BYTES_W'((fill_q + FILL_W'(7)) >> 3) : BYTES_W'(4);
    in_ready   = ~reset & (state_q == ST_RUN) & (fill_q <= FILL_W'(MAX_LEN));
    flush_done = flush_done_q;
    len_err    = len_err_q;
    bit_count  = bit_count_q;
  end

  vlc_code_align u_align (
    .code (in_code),
    .len  (len_eff),
    .fill (fill_s),
    .ins  (ins)
  );

  // Pop shifts first, then the accepted codeword lands at the post-pop offset.
  always_comb begin
    pop     = out_valid & out_ready;
    accept  = in_valid & in_ready;
    len_big = (in_len > LEN_W'(MAX_LEN));
    len_eff = len_big ? LEN_W'(MAX_LEN) : in_len;

    acc_s  = acc_q;
    fill_s = fill_q;
    if (pop && (state_q != ST_LAST)) begin
      acc_s  = acc_q << MAX_LEN;
      fill_s = fill_q - FILL_W'(MAX_LEN);
    end

    acc_d        = acc_s;
    fill_d       = fill_s;
    state_d      = state_q;
    flush_done_d = 1'b0;
    len_err_d    = len_err_q;
    bit_count_d  = bit_count_q;

    if (accept) begin
      acc_d       = acc_s | ins;
      fill_d      = fill_s + FILL_W'(len_eff);
      bit_count_d = bit_count_q + CNT_W'(len_eff);
      if (len_big) begin
        len_err_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_RUN: begin
        // Same-cycle codeword is part of the flushed stream; skip DRAIN when
        // there is no full word left to emit.
        if (flush) begin
          if (fill_d == '0) begin
            flush_done_d = 1'b1;
          end else if (fill_d < FILL_W'(MAX_LEN)) begin
            state_d = ST_LAST;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fill_s == '0) begin
          state_d      = ST_RUN;
          flush_done_d = 1'b1;
        end else if (fill_s < FILL_W'(MAX_LEN)) begin
          state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        // Pad bits below fill are already zero from earlier shifts.
        if (pop) begin
          acc_d        = '0;
          fill_d       = '0;
          state_d      = ST_RUN;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      acc_q        <= '0;
      fill_q       <= '0;
      flush_done_q <= 1'b0;
      len_err_q    <= 1'b0;
      bit_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_done_q <= flush_done_d;
      len_err_q    <= len_err_d;
      bit_count_q  <= bit_count_d;
    end
  end

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Scoreboard bench for vlc_bit_packer: directed vectors push hand-computed
// words, a bit-queue model feeds the random phase, and a monitor pops and
// compares every word the DUT hands over.
module tb_vlc_bit_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_code;
  logic [5:0]  in_len;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [2:0]  out_bytes;
  logic        flush_done;
  logic        len_err;
  logic [31:0] bit_count;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [2:0]  bytes;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   mq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_rdy = 1'b0;
  int   exp_bits = 0;

  always #5 clk = ~clk;

  vlc_bit_packer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_len     (in_len),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_bytes  (out_bytes),
    .flush_done (flush_done),
    .len_err    (len_err),
    .bit_count  (bit_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: every accepted output word must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: got word 0x%08h, expected no word", out_data);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", 64'(out_data), 64'(mon_e.data));
        check("out_last", 64'(out_last), 64'(mon_e.last));
        check("out_bytes", 64'(out_bytes), 64'(mon_e.bytes));
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] d, input logic l, input logic [2:0] b);
    exp_t e;
    e.data  = d;
    e.last  = l;
    e.bytes = b;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] code, input logic [5:0] len);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_code  = code;
    in_len   = len;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      if (!done && rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    if (!done) fail_now("send_timeout");
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (flush_done) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: flush_done not seen in 50 cycles, expected a pulse", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_last"}, 64'(out_last), 64'd0);
    check({tag, "_out_bytes"}, 64'(out_bytes), 64'd4);
    check({tag, "_flush_done"}, 64'(flush_done), 64'd0);
    check({tag, "_len_err"}, 64'(len_err), 64'd0);
    check({tag, "_bit_count"}, 64'(bit_count), 64'd0);
  endtask

  task automatic model_add(input logic [31:0] code, input int len);
    logic [31:0] w;
    for (int i = len - 1; i >= 0; i--) mq.push_back(code[i]);
    while (mq.size() >= 32) begin
      for (int j = 31; j >= 0; j--) w[j] = mq.pop_front();
      sb.push_back(mk(w, 1'b0, 3'd4));
    end
  endtask

  task automatic model_flush();
    logic [31:0] w;
    int          n;
    n = mq.size();
    if (n > 0) begin
      w = '0;
      for (int j = 0; j < n; j++) w[31-j] = mq[j];
      mq.delete();
      sb.push_back(mk(w, 1'b1, 3'((n + 7) / 8)));
    end
  endtask

  initial begin
    int len_r;
    logic [31:0] code_r;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_code   = '0;
    in_len    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("por");
    check("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Eight nibbles 1..8 form one word, visible the cycle after the 8th.
    sb.push_back(mk(32'h12345678, 1'b0, 3'd4));
    for (int v = 1; v <= 8; v++) send(32'(v), 6'd4);
    @(negedge clk);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    // 3'b101 + 32 ones, flushed: full word then a 3-bit padded tail.
    sb.push_back(mk(32'hBFFFFFFF, 1'b0, 3'd4));
    sb.push_back(mk(32'hE0000000, 1'b1, 3'd1));
    send(32'h5, 6'd3);
    send(32'hFFFFFFFF, 6'd32);
    do_flush();
    wait_done("flush_tail");
    check("bit_count_a", 64'(bit_count), 64'd67);

    // Backpressure: two words fill the accumulator, in_ready must drop.
    out_ready = 1'b0;
    sb.push_back(mk(32'hA0A0A0A0, 1'b0, 3'd4));
    sb.push_back(mk(32'hB1B1B1B1, 1'b0, 3'd4));
    sb.push_back(mk(32'hC2C2C2C2, 1'b0, 3'd4));
    send(32'hA0A0A0A0, 6'd32);
    send(32'hB1B1B1B1, 6'd32);
    @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    repeat (3) @(negedge clk);
    check("stall_in_ready_held", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'hC2C2C2C2, 6'd32);
    repeat (3) @(posedge clk);
    #1;
    check("bit_count_b", 64'(bit_count), 64'd163);

    // Flush of an empty packer: done next cycle, no word, single pulse.
    do_flush();
    @(negedge clk);
    check("empty_flush_done", 64'(flush_done), 64'd1);
    check("empty_flush_no_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("empty_flush_pulse", 64'(flush_done), 64'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) send(32'hFFFFFFFF, 6'd0);
    @(negedge clk);
    check("len0_bit_count", 64'(bit_count), 64'd163);
    check("len0_no_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Oversized length clamps to 32 bits and sets the sticky error.
    sb.push_back(mk(32'hA5A5A5A5, 1'b0, 3'd4));
    send(32'hA5A5A5A5, 6'd40);
    @(negedge clk);
    check("len_err_set", 64'(len_err), 64'd1);
    check("len_err_bits", 64'(bit_count), 64'd195);
    @(posedge clk);
    #1;
    send(32'h3C, 6'd8);
    @(negedge clk);
    check("len_err_sticky", 64'(len_err), 64'd1);
    @(posedge clk);
    #1;

    // Reset while draining discards everything buffered.
    out_ready = 1'b0;
    send(32'h12345678, 6'd32);
    do_flush();
    @(negedge clk);
    check("drain_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("mid");
    @(posedge clk);
    #1;

    // Random lengths against the bit-queue model with random backpressure.
    rand_rdy = 1'b1;
    exp_bits = 0;
    for (int k = 0; k < 60; k++) begin
      len_r  = $urandom_range(0, 32);
      code_r = $urandom;
      exp_bits += len_r;
      model_add(code_r, len_r);
      out_ready = ($urandom_range(0, 3) != 0);
      send(code_r, 6'(len_r));
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    model_flush();
    do_flush();
    wait_done("flush_rand");
    check("bit_count_rand", 64'(bit_count), 64'(exp_bits));

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
